// File: rtl/grid_pkg.sv
// Shared types and constants for the grid time-domain blocks.
//   tdc_state_e  : receiver FSM states
//   tdc_result_t : one measured result (magnitude, sign, saturation flag)
//   DIN_W        : magnitude width shared with the DTC driver
//   TDC_WINDOW   : receiver frame length in clk cycles
package grid_pkg;

  localparam int DIN_W      = 8;
  localparam int TDC_WINDOW = 260;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } tdc_state_e;

  // mag is sized by DIN_W; the receiver's W parameter must equal DIN_W.
  typedef struct packed {
    logic [DIN_W-1:0] mag;
    logic             sign;
    logic             ovf;
  } tdc_result_t;

endpackage

// File: rtl/tdc_wabs_rx_out_buf.sv
// One-entry valid/ready holding register for receiver results.
//   clk, rst   : clock, async active-low reset
//   push       : a new result is offered this cycle
//   push_res   : the offered result
//   pop_ready  : consumer accepts the held result when out_valid is high
//   out_valid  : a result is held
//   out_res    : held result; kept unchanged after it is consumed
//   drop       : pulse, a pushed result was discarded because the entry was full
module tdc_out_buf
  import grid_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  tdc_result_t push_res,
  input  logic        pop_ready,
  output logic        out_valid,
  output tdc_result_t out_res,
  output logic        drop
);

  logic        valid_q, valid_d;
  tdc_result_t res_q, res_d;
  logic        load;

  // A push lands when the entry is empty or is being drained this same cycle.
  assign load = push & (~valid_q | pop_ready);
  assign drop = push & valid_q & ~pop_ready;

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    if (load) begin
      valid_d = 1'b1;
      res_d   = push_res;
    end else if (valid_q && pop_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
    end
  end

  assign out_valid = valid_q;
  assign out_res   = res_q;

endmodule

// File: rtl/tdc_wabs_rx.sv
// Time-to-digital receiver: read end of the dtc_wabs pulse link.
// Measures the width of one tac pulse per trig frame and recovers magnitude
// and sign; results leave through a one-entry valid/ready buffer.
//   clk, rst    : clock, async active-low reset
//   trig        : 1-cycle frame start strobe
//   tac_in      : pulse-width-coded magnitude (N high cycles = N)
//   sign_in     : sign accompanying the pulse, sampled on its first cycle
//   dout        : recovered magnitude
//   dout_sign   : recovered sign
//   dout_valid  : result held in the output buffer
//   dout_ready  : consumer handshake
//   ovf         : held result saturated (too long or never fell)
//   err         : sticky; trig inside a frame or result dropped on overrun
//   busy        : FSM not idle
module tdc_wabs_rx
  import grid_pkg::*;
#(
  parameter int W      = DIN_W,
  parameter int WINDOW = TDC_WINDOW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic         tac_in,
  input  logic         sign_in,
  output logic [W-1:0] dout,
  output logic         dout_sign,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  localparam int FC_W = $clog2(WINDOW + 1);
  localparam int MAXC = 2**W - 1;
  localparam logic [FC_W:0]  FC_END = (FC_W+1)'(WINDOW);
  localparam logic [FC_W-1:0] FC_ONE = FC_W'(1);

  tdc_state_e     state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;
  // Extra top bit marks "more than MAXC high cycles seen"; pc parks at MAXC+1.
  logic [W:0]     pc_q, pc_d;
  logic           sign_q, sign_d;
  tdc_result_t    res_q, res_d;
  logic           err_q, err_d;

  logic [FC_W:0]  fc_inc;
  logic           fc_end;
  logic           push;
  logic           trig_err;
  logic           drop;
  tdc_result_t    buf_res;

  // One bit wider so the compare is safe even when fc sits at WINDOW.
  assign fc_inc = {1'b0, fc_q} + 1'b1;
  assign fc_end = (fc_inc >= FC_END);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a trig inside a frame restarts the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (trig) state_d = WAIT;
      WAIT: begin
        if (trig)        state_d = WAIT;
        else if (tac_in) state_d = MEAS;
        else if (fc_end) state_d = DONE;
      end
      MEAS: begin
        if (trig)                 state_d = WAIT;
        else if (!tac_in || fc_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs / datapath
  always_comb begin
    fc_d     = fc_q;
    pc_d     = pc_q;
    sign_d   = sign_q;
    res_d    = res_q;
    push     = 1'b0;
    trig_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          fc_d = FC_ONE;
          pc_d = '0;
        end
      end
      WAIT: begin
        if (trig) begin
          trig_err = 1'b1;
          fc_d     = FC_ONE;
          pc_d     = '0;
        end else begin
          fc_d = fc_inc[FC_W-1:0];
          if (tac_in) begin
            pc_d   = (W+1)'(1);
            sign_d = sign_in;
          end else if (fc_end) begin
            // No pulse within the window encodes code 0.
            res_d = '0;
          end
        end
      end
      MEAS: begin
        if (trig) begin
          trig_err = 1'b1;
          fc_d     = FC_ONE;
          pc_d     = '0;
        end else begin
          fc_d = fc_inc[FC_W-1:0];
          if (tac_in && !fc_end) begin
            pc_d = pc_q[W] ? pc_q : pc_q + 1'b1;
          end else if (tac_in) begin
            // Pulse never fell inside the window.
            res_d = '{mag: W'(MAXC), sign: sign_q, ovf: 1'b1};
          end else begin
            res_d = '{mag:  pc_q[W] ? W'(MAXC) : pc_q[W-1:0],
                      sign: sign_q,
                      ovf:  pc_q[W]};
          end
        end
      end
      DONE: begin
        push     = 1'b1;
        trig_err = trig;
      end
      default: ;
    endcase
    err_d = err_q | trig_err | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fc_q   <= '0;
      pc_q   <= '0;
      sign_q <= 1'b0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      fc_q   <= fc_d;
      pc_q   <= pc_d;
      sign_q <= sign_d;
      res_q  <= res_d;
      err_q  <= err_d;
    end
  end

  tdc_out_buf u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_res  (res_q),
    .pop_ready (dout_ready),
    .out_valid (dout_valid),
    .out_res   (buf_res),
    .drop      (drop)
  );

  assign dout      = buf_res.mag;
  assign dout_sign = buf_res.sign;
  assign ovf       = buf_res.ovf;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_wabs_rx.sv
module tb_tdc_wabs_rx;

  localparam int W      = 8;
  localparam int WINDOW = 260;
  localparam int MAXC   = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trig = 1'b0;
  logic         tac_in = 1'b0;
  logic         sign_in = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_sign, dout_valid, ovf, err, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdc_wabs_rx #(.W(W), .WINDOW(WINDOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .tac_in     (tac_in),
    .sign_in    (sign_in),
    .dout       (dout),
    .dout_sign  (dout_sign),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .err        (err),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; trig = 1'b0; tac_in = 1'b0; sign_in = 1'b0; dout_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
  endtask

  // Cycles from the trig cycle until dout_valid is seen high.
  function automatic int exp_lat(input int n);
    if (n == 0 || n + 3 > WINDOW + 1) return WINDOW + 1;
    return n + 3;
  endfunction

  // DTC-like source: trig, then n high cycles of tac starting next cycle.
  // Optionally pulses dout_ready in cycle rdy_cyc (relative to trig).
  // vlat = first cycle dout_valid was seen high, -1 if never.
  task automatic drive_frame(input int n, input bit s, input int rdy_cyc, output int vlat);
    int len;
    len  = exp_lat(n);
    vlat = -1;
    trig = 1'b1; tac_in = 1'b0; sign_in = s; dout_ready = (rdy_cyc == 0);
    for (int c = 1; c <= len; c++) begin
      tick;
      if (vlat < 0 && dout_valid) vlat = c;
      trig       = 1'b0;
      tac_in     = (c <= n);
      dout_ready = (c == rdy_cyc);
    end
    tac_in = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic pop;
    dout_ready = 1'b1;
    tick;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset;
    int v;
    rst = 1'b0;
    repeat (2) tick;
    checks++;
    if ({dout, dout_sign, dout_valid, ovf, err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {dout, dout_sign, dout_valid, ovf, err, busy});
    end
    rst = 1'b1;
    tick;
    // Hold a result, then reset in the middle of a second measurement (pc=40).
    drive_frame(7, 1'b1, -1, v);
    trig = 1'b1; sign_in = 1'b1;
    tick;
    trig = 1'b0; tac_in = 1'b1;
    repeat (40) tick;
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy busy=%b valid=%b want=1,1", busy, dout_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({dout, dout_sign, dout_valid, ovf, err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h want=0", {dout, dout_sign, dout_valid, ovf, err, busy});
    end
    tac_in = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b want=0", busy);
    end
    drive_frame(12, 1'b0, -1, v);
    checks++;
    if (v !== 15 || dout !== 8'd12 || dout_sign !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_next_frame lat=%0d dout=%0d sign=%b ovf=%b err=%b want 15,12,0,0,0",
               v, dout, dout_sign, ovf, err);
    end
    pop;
  endtask

  task automatic test_basic;
    int v;
    do_reset;
    drive_frame(100, 1'b1, -1, v);
    checks++;
    if (v !== 103) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=103", v);
    end
    checks++;
    if (dout !== 8'd100 || dout_sign !== 1'b1 || ovf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result dout=%0d sign=%b ovf=%b busy=%b want 100,1,0,0",
               dout, dout_sign, ovf, busy);
    end
    pop;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'd100 || dout_sign !== 1'b1) begin
      failures++;
      $display("FAIL basic_pop valid=%b dout=%0d sign=%b want 0,100,1", dout_valid, dout, dout_sign);
    end
  endtask

  task automatic test_zero_full;
    int lens [4] = '{0, 255, 256, 300};
    int v;
    int e_mag;
    bit e_ovf;
    do_reset;
    foreach (lens[i]) begin
      e_mag = (lens[i] > MAXC) ? MAXC : lens[i];
      e_ovf = (lens[i] > MAXC);
      drive_frame(lens[i], 1'b1, -1, v);
      checks++;
      if (v !== exp_lat(lens[i])) begin
        failures++;
        $display("FAIL zf_latency n=%0d got=%0d want=%0d", lens[i], v, exp_lat(lens[i]));
      end
      checks++;
      if (dout !== e_mag[W-1:0] || ovf !== e_ovf || dout_sign !== (lens[i] != 0)) begin
        failures++;
        $display("FAIL zf_result n=%0d dout=%0d ovf=%b sign=%b want %0d,%b,%b",
                 lens[i], dout, ovf, dout_sign, e_mag, e_ovf, lens[i] != 0);
      end
      pop;
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL zf_err got=%b want=0", err);
    end
  endtask

  task automatic test_handshake;
    int v;
    do_reset;
    drive_frame(10, 1'b1, -1, v);
    drive_frame(20, 1'b0, -1, v);
    checks++;
    if (dout !== 8'd10 || dout_sign !== 1'b1 || dout_valid !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL hs_overrun dout=%0d sign=%b valid=%b err=%b want 10,1,1,1",
               dout, dout_sign, dout_valid, err);
    end
    do_reset;
    drive_frame(10, 1'b1, -1, v);
    // Ready in the DONE cycle drains the old result and loads the new one.
    drive_frame(20, 1'b0, exp_lat(20) - 1, v);
    checks++;
    if (dout !== 8'd20 || dout_sign !== 1'b0 || dout_valid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL hs_ready_done dout=%0d sign=%b valid=%b err=%b want 20,0,1,0",
               dout, dout_sign, dout_valid, err);
    end
    pop;
  endtask

  task automatic test_abort;
    int v;
    do_reset;
    trig = 1'b1; sign_in = 1'b1;
    tick;
    trig = 1'b0; tac_in = 1'b1;
    repeat (4) tick;
    // Re-trig 5 cycles into the pulse; the second frame carries a 30-cycle pulse.
    drive_frame(30, 1'b0, -1, v);
    checks++;
    if (v !== 33) begin
      failures++;
      $display("FAIL abort_latency got=%0d want=33", v);
    end
    checks++;
    if (dout !== 8'd30 || dout_sign !== 1'b0 || ovf !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL abort_result dout=%0d sign=%b ovf=%b err=%b want 30,0,0,1",
               dout, dout_sign, ovf, err);
    end
    pop;
  endtask

  task automatic test_back_to_back;
    int v;
    bit e_sign;
    do_reset;
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m <= MAXC; m += 15) begin
        e_sign = (m != 0) && (s == 1);
        drive_frame(m, s[0], -1, v);
        checks++;
        if (v !== exp_lat(m) || dout !== m[W-1:0] || dout_sign !== e_sign || ovf !== 1'b0) begin
          failures++;
          $display("FAIL loop m=%0d s=%0d lat=%0d dout=%0d sign=%b ovf=%b want %0d,%0d,%b,0",
                   m, s, v, dout, dout_sign, ovf, exp_lat(m), m, e_sign);
        end
        pop;
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL loop_err got=%b want=0", err);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_full;
    test_handshake;
    test_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
